// File: rtl/control_sequencer_pkg.sv
// Shared opcodes, T-state one-hot codes and the control-word layout for the SAP-1 sequencer.
package control_sequencer_pkg;

   localparam int RING_W = 6;

   typedef enum logic [3:0] {
      OP_LDA = 4'h0,
      OP_ADD = 4'h1,
      OP_SUB = 4'h2,
      OP_OUT = 4'hE,
      OP_HLT = 4'hF
   } opcode_t;

   localparam logic [RING_W-1:0] T1 = 6'b000001;
   localparam logic [RING_W-1:0] T2 = 6'b000010;
   localparam logic [RING_W-1:0] T3 = 6'b000100;
   localparam logic [RING_W-1:0] T4 = 6'b001000;
   localparam logic [RING_W-1:0] T5 = 6'b010000;
   localparam logic [RING_W-1:0] T6 = 6'b100000;

   // Control word kept active-high internally; the top inverts the _n lines at the ports.
   typedef struct packed {
      logic cp;
      logic ep;
      logic lm;
      logic ce;
      logic li;
      logic ei;
      logic la;
      logic ea;
      logic su;
      logic eu;
      logic lb;
      logic lo;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

   // Every source that can drive the shared W-bus.
   function automatic logic [4:0] bus_drivers(input ctrl_t c);
      return {c.ep, c.ce, c.ei, c.ea, c.eu};
   endfunction

endpackage

// File: rtl/control_sequencer_ring_counter.sv
// One-hot T-state ring: loads T1 on clr, rotates left (last state wraps to T1) when enabled.
module ring_counter #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] t_state
);

   always_ff @(posedge clk) begin
      if (clr)
         t_state <= W'(1);
      else if (en)
         t_state <= {t_state[W-2:0], t_state[W-1]};
   end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1 control unit: T-state ring plus opcode decode driving every W-bus load/enable line.
module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int T_STATES = 6
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                run,
   input  logic [OPCODE_W-1:0] ir_opcode,
   output logic                cp,
   output logic                ep,
   output logic                lm_n,
   output logic                ce_n,
   output logic                li_n,
   output logic                ei_n,
   output logic                la_n,
   output logic                ea,
   output logic                su,
   output logic                eu,
   output logic                lb_n,
   output logic                lo_n,
   output logic                hlt,
   output logic [T_STATES-1:0] t_state
);

   logic [3:0] op;
   logic       halt;
   logic       hlt_t4;
   logic       ring_en;
   ctrl_t      ctrl;

   assign op = ir_opcode[3:0];

   // HLT must stop the ring on the very edge that sets halt, so the ring stays parked in T4.
   assign hlt_t4  = (t_state == T4) && (op == OP_HLT);
   assign ring_en = run && !halt && !hlt_t4;

   ring_counter #(
      .W(T_STATES)
   ) u_ring (
      .clk    (clk),
      .clr    (clr),
      .en     (ring_en),
      .t_state(t_state)
   );

   always_ff @(posedge clk) begin
      if (clr)
         halt <= 1'b0;
      else if (run && hlt_t4)
         halt <= 1'b1;
   end

   always_comb begin
      ctrl = CTRL_IDLE;
      if (!clr && !halt) begin
         unique case (t_state)
            T1: begin
               ctrl.ep = 1'b1;
               ctrl.lm = 1'b1;
            end
            T2: ctrl.cp = 1'b1;
            T3: begin
               ctrl.ce = 1'b1;
               ctrl.li = 1'b1;
            end
            T4: begin
               case (op)
                  OP_LDA, OP_ADD, OP_SUB: begin
                     ctrl.ei = 1'b1;
                     ctrl.lm = 1'b1;
                  end
                  OP_OUT: begin
                     ctrl.ea = 1'b1;
                     ctrl.lo = 1'b1;
                  end
                  default: ;
               endcase
            end
            T5: begin
               case (op)
                  OP_LDA: begin
                     ctrl.ce = 1'b1;
                     ctrl.la = 1'b1;
                  end
                  OP_ADD, OP_SUB: begin
                     ctrl.ce = 1'b1;
                     ctrl.lb = 1'b1;
                     ctrl.su = (op == OP_SUB);
                  end
                  default: ;
               endcase
            end
            T6: begin
               // su already asserted in T5 so the ALU result is settled before the accumulator load.
               if (op == OP_ADD || op == OP_SUB) begin
                  ctrl.eu = 1'b1;
                  ctrl.la = 1'b1;
                  ctrl.su = (op == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   assign cp   = ctrl.cp;
   assign ep   = ctrl.ep;
   assign lm_n = ~ctrl.lm;
   assign ce_n = ~ctrl.ce;
   assign li_n = ~ctrl.li;
   assign ei_n = ~ctrl.ei;
   assign la_n = ~ctrl.la;
   assign ea   = ctrl.ea;
   assign su   = ctrl.su;
   assign eu   = ctrl.eu;
   assign lb_n = ~ctrl.lb;
   assign lo_n = ~ctrl.lo;
   assign hlt  = halt && !clr;

   a_one_hot: assert property (@(posedge clk) disable iff (clr) $onehot(t_state))
      else $error("t_state left one-hot: %b", t_state);

   a_bus_excl: assert property (@(posedge clk) $countones(bus_drivers(ctrl)) <= 1)
      else $error("multiple W-bus drivers active: %b", bus_drivers(ctrl));

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboarded bench for control_sequencer: ISA-level model, a small W-bus datapath, and random run/opcode traffic.
module tb_control_sequencer;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       run = 1'b0;
   logic [3:0] ir_opcode = 4'h0;
   logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n, hlt;
   logic [5:0] t_state;

   control_sequencer dut (
      .clk(clk), .clr(clr), .run(run), .ir_opcode(ir_opcode),
      .cp(cp), .ep(ep), .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n), .ei_n(ei_n),
      .la_n(la_n), .ea(ea), .su(su), .eu(eu), .lb_n(lb_n), .lo_n(lo_n),
      .hlt(hlt), .t_state(t_state)
   );

   always #5 clk = ~clk;

   // Active-high view of the outputs: {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo,hlt}
   localparam int B_CP = 12, B_EP = 11, B_LM = 10, B_CE = 9, B_LI = 8, B_EI = 7;
   localparam int B_LA = 6, B_EA = 5, B_SU = 4, B_EU = 3, B_LB = 2, B_LO = 1, B_HLT = 0;
   logic [12:0] cw;
   assign cw = {cp, ep, ~lm_n, ~ce_n, ~li_n, ~ei_n, ~la_n, ea, su, eu, ~lb_n, ~lo_n, hlt};

   // Tiny SAP-1 datapath driven by the DUT's control lines.
   logic [7:0] ram [16];
   logic [3:0] dp_pc = 4'h0, dp_mar = 4'h0;
   logic [7:0] dp_ir = 8'h00, dp_a = 8'h00, dp_b = 8'h00, dp_out = 8'h00;
   logic [7:0] bus, alu;

   always_comb begin
      alu = su ? (dp_a - dp_b) : (dp_a + dp_b);
      bus = 8'h00;
      if (ep)         bus = {4'h0, dp_pc};
      else if (!ce_n) bus = ram[dp_mar];
      else if (!ei_n) bus = {4'h0, dp_ir[3:0]};
      else if (ea)    bus = dp_a;
      else if (eu)    bus = alu;
   end

   always @(posedge clk) begin
      if (clr)   dp_pc  <= 4'h0;
      else if (cp) dp_pc <= dp_pc + 4'h1;
      if (!lm_n) dp_mar <= bus[3:0];
      if (!li_n) dp_ir  <= bus;
      if (!la_n) dp_a   <= bus;
      if (!lb_n) dp_b   <= bus;
      if (!lo_n) dp_out <= bus;
   end

   // Reference model: instruction step (0 = T1 .. 5 = T6) and halted flag.
   int   m_k = 0;
   bit   m_halted = 1'b0;
   bit   dp_mode = 1'b0;
   int   tests = 0;
   int   fails = 0;

   typedef struct {
      logic [5:0]  t;
      logic [12:0] cw;
   } exp_t;
   exp_t        exp_q[$];
   logic [15:0] dp_q[$];

   function automatic logic [12:0] exp_ctrl(input int k, input logic [3:0] op, input bit halted, input logic c);
      logic [12:0] v = '0;
      if (c) return v;
      if (halted) begin
         v[B_HLT] = 1'b1;
         return v;
      end
      case (k)
         0: begin v[B_EP] = 1'b1; v[B_LM] = 1'b1; end
         1: v[B_CP] = 1'b1;
         2: begin v[B_CE] = 1'b1; v[B_LI] = 1'b1; end
         3: if (op <= 4'h2) begin v[B_EI] = 1'b1; v[B_LM] = 1'b1; end
            else if (op == 4'hE) begin v[B_EA] = 1'b1; v[B_LO] = 1'b1; end
         4: if (op == 4'h0) begin v[B_CE] = 1'b1; v[B_LA] = 1'b1; end
            else if (op == 4'h1 || op == 4'h2) begin
               v[B_CE] = 1'b1; v[B_LB] = 1'b1; v[B_SU] = (op == 4'h2);
            end
         5: if (op == 4'h1 || op == 4'h2) begin
               v[B_EU] = 1'b1; v[B_LA] = 1'b1; v[B_SU] = (op == 4'h2);
            end
         default: ;
      endcase
      return v;
   endfunction

   task automatic step(input logic c, input logic r, input logic [3:0] op);
      exp_t e;
      clr = c;
      run = r;
      ir_opcode = op;
      e.t  = 6'(1 << m_k);
      e.cw = exp_ctrl(m_k, op, m_halted, c);
      exp_q.push_back(e);
      if (c) begin
         m_k = 0;
         m_halted = 1'b0;
      end else if (r && !m_halted) begin
         if (m_k == 3 && op == 4'hF) m_halted = 1'b1;
         else m_k = (m_k + 1) % 6;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic dstep(input logic c, input logic r);
      step(c, r, dp_ir[7:4]);
   endtask

   // Instruction-level interpretation of the RAM program: accumulator/output after each instruction.
   task automatic build_dp_expect();
      int pc = 0;
      logic [7:0] a = 8'h00, o = 8'h00, ins;
      for (int n = 0; n < 16; n++) begin
         ins = ram[pc];
         pc++;
         if (ins[7:4] == 4'hF) break;
         case (ins[7:4])
            4'h0: a = ram[ins[3:0]];
            4'h1: a = a + ram[ins[3:0]];
            4'h2: a = a - ram[ins[3:0]];
            4'hE: o = a;
            default: ;
         endcase
         dp_q.push_back({a, o});
      end
   endtask

   logic [5:0] prev_t = 6'h00;
   always @(negedge clk) begin
      exp_t e;
      logic [15:0] d;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         tests++;
         if (t_state !== e.t) begin
            fails++;
            $display("FAIL t_state: got %b want %b at %0t", t_state, e.t, $time);
         end
         tests++;
         if (cw !== e.cw) begin
            fails++;
            $display("FAIL ctrl_word t=%b: got %b want %b at %0t", t_state, cw, e.cw, $time);
         end
      end
      if (dp_mode && prev_t == 6'b100000 && t_state == 6'b000001) begin
         tests++;
         if (dp_q.size() == 0) begin
            fails++;
            $display("FAIL dp_extra_instr: got completion, want none at %0t", $time);
         end else begin
            d = dp_q.pop_front();
            if ({dp_a, dp_out} !== d) begin
               fails++;
               $display("FAIL dp_acc_out: got A=%h OUT=%h want A=%h OUT=%h", dp_a, dp_out, d[15:8], d[7:0]);
            end
         end
      end
      prev_t = t_state;
   end

   initial begin
      for (int i = 0; i < 16; i++) ram[i] = 8'h00;
      ram[0] = 8'h09;  // LDA 9
      ram[1] = 8'h0A;  // LDA 10
      ram[2] = 8'h1B;  // ADD 11
      ram[3] = 8'h2B;  // SUB 11
      ram[4] = 8'hE0;  // OUT
      ram[5] = 8'h30;  // NOP
      ram[6] = 8'hF0;  // HLT
      ram[9]  = 8'h2A;
      ram[10] = 8'h05;
      ram[11] = 8'h03;
      build_dp_expect();

      clr = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      dp_mode = 1'b1;
      dstep(1'b1, 1'b0);
      repeat (8) dstep(1'b0, 1'b1);
      repeat (5) dstep(1'b0, 1'b0);
      for (int i = 0; i < 200 && !m_halted; i++) dstep(1'b0, 1'b1);
      repeat (20) dstep(1'b0, 1'b1);
      tests++;
      if (dp_q.size() != 0) begin
         fails++;
         $display("FAIL dp_pending: got %0d instructions uncompleted, want 0", dp_q.size());
      end
      dp_mode = 1'b0;
      dstep(1'b1, 1'b1);
      repeat (3) dstep(1'b0, 1'b1);

      for (int i = 0; i < 10000; i++) begin
         logic       c, r;
         logic [3:0] op;
         int         sel;
         c = ($urandom_range(0, 99) < 3);
         r = ($urandom_range(0, 9) != 0);
         sel = $urandom_range(0, 7);
         case (sel)
            0: op = 4'h0;
            1: op = 4'h1;
            2: op = 4'h2;
            3: op = 4'hE;
            4: op = 4'hF;
            default: op = 4'($urandom_range(0, 15));
         endcase
         step(c, r, op);
      end

      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
